// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, single-outstanding
// memory handshake, prefetch FIFO to the core, redirect with in-flight drain.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]             tgt_q, tgt_d;
  logic [DEPTH-1:0][DATA_W-1:0]  data_q;
  logic [DEPTH-1:0][ADDR_W-1:0]  pcs_q;
  logic [PW-1:0]                 rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]                 count_q, count_d;
  logic                          push, pop;

  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pcs_q[rd_ptr_q];
  assign imem_addr   = fetch_pc_q;

  // A redirect overrides both sides of the FIFO: acked data is dropped, pop ignored.
  assign push = (state_q == REQ) && imem_ack && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    count_d = count_q;
    if (redirect_valid) count_d = '0;
    else                count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tgt_d      = tgt_q;
    imem_req   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = REQ;
        end else if (count_q < CW'(DEPTH)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          if (imem_ack) begin
            fetch_pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
          if (count_d >= CW'(DEPTH)) state_d = IDLE;
        end
      end
      DRAIN: begin
        // Hold the old request until memory acks it; the answer is thrown away.
        imem_req = 1'b1;
        if (redirect_valid) tgt_d = redirect_pc;
        if (imem_ack) begin
          fetch_pc_d = tgt_d;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      tgt_q      <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      data_q     <= '0;
      pcs_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tgt_q      <= tgt_d;
      count_q    <= count_d;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= imem_rdata;
          pcs_q[wr_ptr_q]  <= fetch_pc_q;
          wr_ptr_q         <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model with programmable latency, an
// instruction-stream scoreboard, and directed plus randomized scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int delivered = 0;

  // memory model: ack after lat wait cycles, or under manual control
  int   lat = 0;
  logic man = 1'b0;
  logic man_ack = 1'b0;
  int   wcnt;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  assign imem_ack   = imem_req && (man ? man_ack : (wcnt >= lat));
  assign imem_rdata = imem_addr ^ 16'hA5A5;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  // Scoreboard: the core must see a gap-free +2 stream starting at the reset
  // PC or at the most recent redirect target, each word = pc ^ A5A5.
  logic [15:0] exp_pc;
  logic        pend;
  logic [15:0] pend_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 16'h0000;
      pend   = 1'b0;
    end else begin
      if (pend) begin
        total++;
        if (!(imem_req && imem_addr == pend_addr)) begin
          bad++;
          $display("FAIL req_hold: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, pend_addr);
        end
      end
      if (redirect_valid) exp_pc = redirect_pc;
      else if (instr_valid && instr_ready) begin
        total++;
        delivered++;
        if (instr_pc !== exp_pc || instr !== (exp_pc ^ 16'hA5A5)) begin
          bad++;
          $display("FAIL stream: got pc=%h instr=%h required pc=%h instr=%h", instr_pc, instr, exp_pc, exp_pc ^ 16'hA5A5);
        end
        exp_pc = exp_pc + 16'd2;
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h1234;
    tick();
    total += 5;
    if (imem_req !== 1'b0)       begin bad++; $display("FAIL rst_req: got %b required 0", imem_req); end
    if (imem_addr !== 16'h0000)  begin bad++; $display("FAIL rst_addr: got %h required 0000", imem_addr); end
    if (instr_valid !== 1'b0)    begin bad++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
    if (instr !== 16'h0000)      begin bad++; $display("FAIL rst_instr: got %h required 0000", instr); end
    if (instr_pc !== 16'h0000)   begin bad++; $display("FAIL rst_pc: got %h required 0000", instr_pc); end
    redirect_valid = 1'b0;
  endtask

  task automatic test_cold_start();
    logic [15:0] a, p;
    man = 1'b0; lat = 0; instr_ready = 1'b1;
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'(2 * i);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        bad++; $display("FAIL cold_addr: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, a);
      end
      if (i > 0) begin
        p = 16'(2 * (i - 1));
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== p || instr !== (p ^ 16'hA5A5)) begin
          bad++; $display("FAIL cold_instr: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                          instr_valid, instr_pc, instr, p, p ^ 16'hA5A5);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int nreq, n;
    logic [15:0] a;
    man = 1'b0; lat = 0; instr_ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (imem_req && imem_ack) begin
        a = 16'(2 * nreq);
        total++;
        if (imem_addr !== a) begin bad++; $display("FAIL bp_addr: got %h required %h", imem_addr, a); end
        nreq++;
      end
      tick();
    end
    total += 3;
    if (nreq != 4) begin bad++; $display("FAIL bp_nreq: got %0d required 4", nreq); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_idle: got req=%b required 0", imem_req); end
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin
      bad++; $display("FAIL bp_head: got v=%b pc=%h required v=1 pc=0000", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    n = 0;
    while (!imem_req && n < 8) begin tick(); n++; end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
      bad++; $display("FAIL bp_resume: got req=%b addr=%h required req=1 addr=0008", imem_req, imem_addr);
    end
    repeat (8) tick();
  endtask

  task automatic test_drain();
    int n;
    man = 1'b0; lat = 3; instr_ready = 1'b1;
    do_reset();
    n = 0;
    while (!(imem_req && imem_addr == 16'h0004) && n < 50) begin tick(); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL drain_find: addr 0004 never requested, got %h", imem_addr); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    total += 2;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
      bad++; $display("FAIL drain_hold: got req=%b addr=%h required req=1 addr=0004", imem_req, imem_addr);
    end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL drain_flush: got v=%b required 0", instr_valid); end
    tick();
    n = 0;
    while (imem_addr == 16'h0004 && n < 20) begin tick(); n++; end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
      bad++; $display("FAIL drain_next: got req=%b addr=%h required req=1 addr=0100", imem_req, imem_addr);
    end
    n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || instr !== 16'hA4A5) begin
      bad++; $display("FAIL drain_first: got v=%b pc=%h instr=%h required v=1 pc=0100 instr=A4A5", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_redirect_on_ack();
    int n;
    man = 1'b1; man_ack = 1'b1; instr_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    man_ack = 1'b0;
    instr_ready = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
      bad++; $display("FAIL rda_req: got req=%b addr=%h required req=1 addr=0008", imem_req, imem_addr);
    end
    man_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    total++;
    if (imem_ack !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 16'h0004) begin
      bad++; $display("FAIL rda_pre: got ack=%b v=%b pc=%h required ack=1 v=1 pc=0004", imem_ack, instr_valid, instr_pc);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || imem_addr !== 16'h0040) begin
      bad++; $display("FAIL rda_post: got v=%b addr=%h required v=0 addr=0040", instr_valid, imem_addr);
    end
    tick();
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0040) begin
      bad++; $display("FAIL rda_first: got v=%b pc=%h required v=1 pc=0040", instr_valid, instr_pc);
    end
    man = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] wexp [4];
    int k, n;
    wexp[0] = 16'hFFFC; wexp[1] = 16'hFFFE; wexp[2] = 16'h0000; wexp[3] = 16'h0002;
    man = 1'b0; lat = 0; instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFC;
    tick();
    redirect_valid = 1'b0;
    k = 0; n = 0;
    while (k < 4 && n < 30) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        total++;
        if (instr_pc !== wexp[k]) begin bad++; $display("FAIL wrap_pc%0d: got %h required %h", k, instr_pc, wexp[k]); end
        k++;
      end
      tick();
      n++;
    end
    total++;
    if (k != 4) begin bad++; $display("FAIL wrap_count: got %0d deliveries required 4", k); end
  endtask

  task automatic test_async_reset();
    int n;
    man = 1'b0; lat = 3; instr_ready = 1'b0;
    do_reset();
    n = 0;
    while (!(instr_valid && imem_req) && n < 30) begin tick(); n++; end
    total++;
    if (!(instr_valid && imem_req)) begin bad++; $display("FAIL ar_setup: got v=%b req=%b required 1 1", instr_valid, imem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 16'h0000) begin
      bad++; $display("FAIL ar_drop: got req=%b v=%b addr=%h required 0 0 0000", imem_req, instr_valid, imem_addr);
    end
    tick();
    tick();
    rst_n = 1'b1;
    lat = 0;
    tick();
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++; $display("FAIL ar_restart: got req=%b addr=%h required req=1 addr=0000", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_random();
    int d0;
    man = 1'b0;
    d0 = delivered;
    for (int c = 0; c < 3000; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(0, 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 16'($urandom());
      tick();
    end
    redirect_valid = 1'b0;
    total++;
    if (delivered - d0 < 200) begin bad++; $display("FAIL rand_progress: got %0d deliveries required >=200", delivered - d0); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_start();
    test_backpressure();
    test_drain();
    test_redirect_on_ack();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
